// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch / execute / memory control FSM.
// Fetches over a req/ack instruction port, decodes IR[n-1:n-5], sequences the data-memory
// handshake for LW/SW and commits each instruction with a one-cycle pc_en strobe.
// Requests and datapath controls are decoded from the registered state and IR, so they
// clear together with the asynchronous reset. They also follow the live ack/zero inputs
// in the cycle those inputs arrive. Status outputs (halted, trap, trap_cause, retired)
// are registered.
module control_sequencer #(
    parameter int unsigned n       = 32,
    parameter int unsigned CW      = 16,
    parameter int unsigned TIMEOUT = 255,
    parameter logic [3:0]  ALU_ADD = 4'h2,
    parameter logic [3:0]  ALU_SUB = 4'h6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic [n-1:0]  imem_rdata,
    output logic          dmem_req,
    input  logic          dmem_ack,
    input  logic          zero,
    output logic [n-1:0]  instruction,
    output logic          regDst,
    output logic          regWrite,
    output logic          branch,
    output logic          memWrite,
    output logic          memToReg,
    output logic          jump,
    output logic          jalSelect,
    output logic          jalSelect2,
    output logic          jrSelect,
    output logic          aluSrc,
    output logic          branchMuxSelect,
    output logic [3:0]    aluControl,
    output logic          pc_en,
    output logic          halted,
    output logic          trap,
    output logic [1:0]    trap_cause,
    output logic [CW-1:0] retired
);

    localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT,
        S_TRAP
    } state_t;

    state_t        r_state;
    logic [n-1:0]  r_ir;
    logic [WW-1:0] r_wait;
    logic [CW-1:0] r_retired;
    logic          r_halted;
    logic          r_trap;
    logic [1:0]    r_cause;

    logic [4:0] w_op;
    logic       w_regDst, w_regWrite, w_branch, w_memWrite, w_memToReg, w_jump;
    logic       w_jalSelect, w_jalSelect2, w_jrSelect, w_aluSrc;
    logic [3:0] w_alu;
    logic       w_legal, w_is_mem, w_is_halt;
    logic       w_active;

    assign w_op = r_ir[n-1 -: 5];

    // Opcode decode of the latched instruction register.
    always_comb begin
        w_regDst     = 1'b0;
        w_regWrite   = 1'b0;
        w_branch     = 1'b0;
        w_memWrite   = 1'b0;
        w_memToReg   = 1'b0;
        w_jump       = 1'b0;
        w_jalSelect  = 1'b0;
        w_jalSelect2 = 1'b0;
        w_jrSelect   = 1'b0;
        w_aluSrc     = 1'b0;
        w_alu        = ALU_ADD;
        w_legal      = 1'b1;
        w_is_mem     = 1'b0;
        w_is_halt    = 1'b0;
        case (w_op)
            5'h00: begin w_regDst = 1'b1; w_regWrite = 1'b1; w_alu = r_ir[3:0]; end
            5'h01: begin w_aluSrc = 1'b1; w_regWrite = 1'b1; end
            5'h02: begin w_aluSrc = 1'b1; w_memToReg = 1'b1; w_regWrite = 1'b1; w_is_mem = 1'b1; end
            5'h03: begin w_aluSrc = 1'b1; w_memWrite = 1'b1; w_is_mem = 1'b1; end
            5'h04: begin w_branch = 1'b1; w_alu = ALU_SUB; end
            5'h05: w_jump = 1'b1;
            5'h06: begin w_jump = 1'b1; w_regWrite = 1'b1; w_jalSelect = 1'b1; w_jalSelect2 = 1'b1; end
            5'h07: w_jrSelect = 1'b1;
            5'h1F: w_is_halt = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_active = (r_state == S_EXEC) || (r_state == S_MEM);

    // Drive requests and datapath controls from state; commit strobes in EXEC or MEM-ack cycle.
    always_comb begin
        imem_req        = (r_state == S_FETCH);
        dmem_req        = (r_state == S_MEM);
        regDst          = w_active & w_regDst;
        branch          = w_active & w_branch;
        memWrite        = w_active & w_memWrite;
        memToReg        = w_active & w_memToReg;
        jump            = w_active & w_jump;
        jalSelect       = w_active & w_jalSelect;
        jalSelect2      = w_active & w_jalSelect2;
        jrSelect        = w_active & w_jrSelect;
        aluSrc          = w_active & w_aluSrc;
        branchMuxSelect = w_active & w_branch & zero;
        aluControl      = w_active ? w_alu : 4'h0;
        regWrite        = 1'b0;
        pc_en           = 1'b0;
        if (r_state == S_EXEC) begin
            regWrite = w_regWrite & ~w_is_mem;
            pc_en    = w_legal & ~w_is_mem & ~w_is_halt;
        end else if (r_state == S_MEM) begin
            regWrite = w_regWrite & dmem_ack;
            pc_en    = dmem_ack;
        end
    end

    assign instruction = r_ir;
    assign retired     = r_retired;
    assign halted      = r_halted;
    assign trap        = r_trap;
    assign trap_cause  = r_cause;

    // Sequencer state, IR, wait counter, retire counter and sticky status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ir      <= '0;
            r_wait    <= '0;
            r_retired <= '0;
            r_halted  <= 1'b0;
            r_trap    <= 1'b0;
            r_cause   <= 2'b00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                        r_wait  <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_EXEC;
                    end else if (TO_EN && (r_wait == W_LAST)) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 2'b10;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_EXEC: begin
                    r_wait <= '0;
                    if (!w_legal) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 2'b01;
                    end else if (w_is_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (w_is_mem) begin
                        r_state <= S_MEM;
                    end else begin
                        r_retired <= r_retired + CW'(1);
                        r_state   <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_retired <= r_retired + CW'(1);
                        r_state   <= S_FETCH;
                        r_wait    <= '0;
                    end else if (TO_EN && (r_wait == W_LAST)) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 2'b11;
                    end else begin
                        r_wait <= r_wait + WW'(1);
                    end
                end
                S_HALT: r_state <= S_HALT;
                S_TRAP: r_state <= S_TRAP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a transaction-level driver that knows, per instruction, what
// every output must be in each cycle, plus a per-cycle compare process and literal spot checks.
module tb_control_sequencer;

    localparam int unsigned NB  = 32;
    localparam int unsigned CWB = 4;
    localparam int unsigned TO  = 4;
    localparam logic [3:0]  ADD = 4'h2;
    localparam logic [3:0]  SUB = 4'h6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          imem_ack = 1'b0;
    logic [NB-1:0] imem_rdata = '0;
    logic          dmem_ack = 1'b0;
    logic          zero = 1'b0;
    logic          imem_req, dmem_req;
    logic [NB-1:0] instruction;
    logic          regDst, regWrite, branch, memWrite, memToReg, jump;
    logic          jalSelect, jalSelect2, jrSelect, aluSrc, branchMuxSelect;
    logic [3:0]    aluControl;
    logic          pc_en, halted, trap;
    logic [1:0]    trap_cause;
    logic [CWB-1:0] retired;

    control_sequencer #(
        .n(NB), .CW(CWB), .TIMEOUT(TO), .ALU_ADD(ADD), .ALU_SUB(SUB)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .zero(zero),
        .instruction(instruction),
        .regDst(regDst), .regWrite(regWrite), .branch(branch), .memWrite(memWrite),
        .memToReg(memToReg), .jump(jump), .jalSelect(jalSelect), .jalSelect2(jalSelect2),
        .jrSelect(jrSelect), .aluSrc(aluSrc), .branchMuxSelect(branchMuxSelect),
        .aluControl(aluControl), .pc_en(pc_en), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [14:0] dut_ctrl;
    assign dut_ctrl = {regDst, regWrite, branch, memWrite, memToReg, jump, jalSelect,
                       jalSelect2, jrSelect, aluSrc, branchMuxSelect, aluControl};

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    // expected output values for the current cycle
    logic           e_ireq = 1'b0, e_dreq = 1'b0, e_pc = 1'b0, e_halt = 1'b0, e_trap = 1'b0;
    logic [1:0]     e_cause = 2'b00;
    logic [CWB-1:0] e_ret = '0;
    logic [NB-1:0]  e_ir = '0;
    logic [14:0]    e_ctrl = '0;

    // activity counters observed on the DUT, cleared by the driver
    int unsigned ireq_cnt = 0, dreq_cnt = 0, rw_cnt = 0, pc_cnt = 0, bms_cnt = 0;
    // DUT outputs captured mid-EXEC cycle by exec_instr
    logic [3:0] x_alu;
    logic       x_pc, x_as, x_rw, x_bms;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec decode table; regWrite appears only in the commit cycle.
    function automatic logic [14:0] ctrl_of(input logic [NB-1:0] ir, input logic z, input logic commit);
        logic rd, rw, br, mw, m2r, j, js, js2, jr, as, bms;
        logic [3:0] alu;
        {rd, rw, br, mw, m2r, j, js, js2, jr, as, bms} = '0;
        alu = ADD;
        case (ir[31:27])
            5'h00: begin rd = 1; rw = 1; alu = ir[3:0]; end
            5'h01: begin as = 1; rw = 1; end
            5'h02: begin as = 1; m2r = 1; rw = 1; end
            5'h03: begin as = 1; mw = 1; end
            5'h04: begin br = 1; alu = SUB; bms = z; end
            5'h05: j = 1;
            5'h06: begin j = 1; rw = 1; js = 1; js2 = 1; end
            5'h07: jr = 1;
            default: ;
        endcase
        return {rd, rw & commit, br, mw, m2r, j, js, js2, jr, as, bms, alu};
    endfunction

    // Per-cycle comparison against the expectations, sampled mid-cycle.
    always @(negedge clk) begin
        chk("imem_req", imem_req, e_ireq);
        chk("dmem_req", dmem_req, e_dreq);
        chk("controls", dut_ctrl, e_ctrl);
        chk("pc_en", pc_en, e_pc);
        chk("halted", halted, e_halt);
        chk("trap", trap, e_trap);
        chk("trap_cause", trap_cause, e_cause);
        chk("retired", retired, e_ret);
        chk("instruction", instruction, e_ir);
        if (imem_req) ireq_cnt++;
        if (dmem_req) dreq_cnt++;
        if (regWrite) rw_cnt++;
        if (pc_en) pc_cnt++;
        if (branchMuxSelect) bms_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        e_ireq = 0; e_dreq = 0; e_pc = 0; e_ctrl = '0;
    endtask

    task automatic clr_cnt();
        ireq_cnt = 0; dreq_cnt = 0; rw_cnt = 0; pc_cnt = 0; bms_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 0; run = 0; imem_ack = 0; dmem_ack = 0;
        quiet();
        e_ret = '0; e_ir = '0; e_halt = 0; e_trap = 0; e_cause = 2'b00;
        repeat (2) cyc();
        reset = 1;
        // a couple of IDLE cycles with stray acks, which must be ignored
        repeat (2) begin
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom); zero = 1'($urandom);
            cyc();
        end
    endtask

    task automatic start();
        run = 1; quiet();
        imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
        cyc();
        imem_ack = 0; dmem_ack = 0;
    endtask

    // Cycles in an absorbing state: nothing but the sticky flags may show.
    task automatic idle_cycles(input int unsigned k);
        for (int unsigned i = 0; i < k; i++) begin
            quiet();
            run = 1'($urandom); imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
            zero = 1'($urandom); imem_rdata = $urandom;
            cyc();
        end
        imem_ack = 0; dmem_ack = 0;
    endtask

    task automatic fetch(input logic [NB-1:0] w, input int unsigned wt);
        for (int unsigned i = 0; i <= wt; i++) begin
            quiet(); e_ireq = 1;
            imem_ack = (i == wt);
            imem_rdata = (i == wt) ? w : $urandom;
            dmem_ack = 1'($urandom); zero = 1'($urandom); run = 1'($urandom);
            cyc();
        end
        imem_ack = 0;
        e_ir = w;
    endtask

    // One instruction from fetch to commit/trap. zsel: 0/1 force zero, 2 random.
    // mw >= TO means dmem never acks.
    task automatic exec_instr(input logic [NB-1:0] w, input int unsigned fw,
                              input int unsigned mw, input int unsigned zsel);
        logic [4:0] op;
        logic ismem;
        op = w[31:27];
        ismem = (op == 5'h02) || (op == 5'h03);
        fetch(w, fw);
        quiet();
        zero = (zsel == 2) ? 1'($urandom) : 1'(zsel);
        imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
        if (ismem) begin
            e_ctrl = ctrl_of(w, zero, 0);
        end else if (op <= 5'h07) begin
            e_ctrl = ctrl_of(w, zero, 1);
            e_pc = 1;
        end else begin
            e_ctrl = ctrl_of(w, zero, 0);
        end
        #1;
        x_alu = aluControl; x_pc = pc_en; x_as = aluSrc; x_rw = regWrite; x_bms = branchMuxSelect;
        cyc();
        imem_ack = 0; dmem_ack = 0;
        if (ismem) begin
            if (mw >= TO) begin
                for (int unsigned i = 0; i < TO; i++) begin
                    quiet(); e_dreq = 1;
                    zero = 1'($urandom); imem_ack = 1'($urandom);
                    e_ctrl = ctrl_of(w, zero, 0);
                    cyc();
                end
                e_trap = 1; e_cause = 2'b11;
            end else begin
                for (int unsigned i = 0; i <= mw; i++) begin
                    quiet(); e_dreq = 1;
                    zero = 1'($urandom); imem_ack = 1'($urandom);
                    dmem_ack = (i == mw);
                    e_ctrl = ctrl_of(w, zero, dmem_ack);
                    e_pc = dmem_ack;
                    cyc();
                end
                e_ret = e_ret + 1'b1;
            end
        end else if (op <= 5'h07) begin
            e_ret = e_ret + 1'b1;
        end else if (op == 5'h1F) begin
            e_halt = 1;
        end else begin
            e_trap = 1; e_cause = 2'b01;
        end
        quiet();
        imem_ack = 0; dmem_ack = 0;
    endtask

    function automatic logic [NB-1:0] mk(input logic [4:0] op);
        logic [31:0] r;
        r = $urandom;
        return {op, r[26:0]};
    endfunction

    logic [NB-1:0] wl;

    initial begin
        do_reset();

        // ADDI, ack in first fetch cycle
        start();
        clr_cnt();
        exec_instr(mk(5'h01), 0, 0, 2);
        chk("t1_aluSrc", x_as, 1'b1);
        chk("t1_regWrite", x_rw, 1'b1);
        chk("t1_pc_en", x_pc, 1'b1);
        chk("t1_retired", retired, 4'd1);
        chk("t1_back_in_fetch", imem_req, 1'b1);

        // LW with dmem_ack on the fourth MEM cycle
        clr_cnt();
        exec_instr(mk(5'h02), 1, 3, 2);
        chk("t2_dreq_cycles", dreq_cnt, 4);
        chk("t2_regWrite_cycles", rw_cnt, 1);
        chk("t2_pc_en_cycles", pc_cnt, 1);

        // BEQ taken then not taken
        clr_cnt();
        exec_instr(mk(5'h04), 0, 0, 1);
        chk("t3_alu_sub", x_alu, 4'h6);
        chk("t3_bms_z1", x_bms, 1'b1);
        exec_instr(mk(5'h04), 2, 0, 0);
        chk("t3_bms_z0", x_bms, 1'b0);
        chk("t3_pc_en_cycles", pc_cnt, 2);
        chk("t3_bms_cycles", bms_cnt, 1);

        // R-type with explicit function field
        exec_instr({5'h00, 21'h0, 2'b11, 4'h9}, 0, 0, 2);
        chk("rtype_alu_func", x_alu, 4'h9);

        // random legal instruction stream, enough commits to wrap retired
        for (int unsigned k = 0; k < 60; k++) begin
            exec_instr(mk(5'($urandom_range(0, 7))), $urandom_range(0, TO - 1),
                       $urandom_range(0, TO - 1), 2);
        end

        // HALT is absorbing
        exec_instr(mk(5'h1F), 1, 0, 2);
        clr_cnt();
        idle_cycles(6);
        chk("halt_no_fetch", ireq_cnt, 0);
        chk("halt_flag", halted, 1'b1);
        chk("halt_no_pc_en", pc_cnt, 0);

        // illegal opcode 0x0A
        do_reset();
        start();
        clr_cnt();
        exec_instr({5'h0A, 27'h1234567}, 0, 0, 2);
        chk("t4_pc_en_never", pc_cnt, 0);
        clr_cnt();
        idle_cycles(6);
        chk("t4_trap", trap, 1'b1);
        chk("t4_cause", trap_cause, 2'b01);
        chk("t4_no_fetch", ireq_cnt, 0);

        // imem timeout
        do_reset();
        start();
        clr_cnt();
        for (int unsigned i = 0; i < TO; i++) begin
            quiet(); e_ireq = 1; imem_ack = 0; dmem_ack = 1'($urandom);
            cyc();
        end
        e_trap = 1; e_cause = 2'b10;
        idle_cycles(3);
        chk("t5_req_cycles", ireq_cnt, 4);
        chk("t5_cause", trap_cause, 2'b10);

        // dmem timeout
        do_reset();
        start();
        exec_instr(mk(5'h03), 0, 99, 2);
        idle_cycles(3);
        chk("dmem_to_cause", trap_cause, 2'b11);

        // reset asserted in the middle of MEM
        do_reset();
        start();
        exec_instr(mk(5'h01), 0, 0, 2);
        wl = mk(5'h02);
        fetch(wl, 0);
        quiet(); zero = 1'($urandom); e_ctrl = ctrl_of(wl, zero, 0);
        cyc();
        quiet(); e_dreq = 1; dmem_ack = 0; e_ctrl = ctrl_of(wl, zero, 0);
        #2;
        chk("t6_dreq_before", dmem_req, 1'b1);
        reset = 0;
        quiet(); e_ret = '0; e_ir = '0;
        #1;
        chk("t6_dreq_dropped", dmem_req, 1'b0);
        chk("t6_ctrl_zero", dut_ctrl, 15'h0);
        chk("t6_retired_zero", retired, 4'd0);
        @(posedge clk); #1;
        cyc();
        reset = 1;
        idle_cycles(0);
        quiet(); run = 0;
        cyc();
        start();
        exec_instr(mk(5'h06), 1, 0, 2);
        chk("t6_resume_retired", retired, 4'd1);
        exec_instr(mk(5'h05), 0, 0, 2);
        exec_instr(mk(5'h07), 0, 0, 2);
        chk("t6_retired_3", retired, 4'd3);

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
